// File: rtl/alu_pkg.sv
// Shared widths, PSR bit positions and ALU opcode encodings for the operand stage.
// Optional same-cycle bypass is selected with the OPSTAGE_BYPASS_EN macro in alu_operand_stage.
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 16;
  localparam int ADDR_W  = 4;
  localparam int OP_W    = 8;
  localparam int FLAG_W  = 5;
  localparam int IMM_W   = 8;

  // PSR layout ZCFNL
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 8'h01,
    OP_OR    = 8'h02,
    OP_XOR   = 8'h03,
    OP_NOT   = 8'h04,
    OP_ADD   = 8'h05,
    OP_ADDU  = 8'h06,
    OP_ADDC  = 8'h07,
    OP_ADDCU = 8'h08,
    OP_SUB   = 8'h09,
    OP_CMPU  = 8'h0A,
    OP_CMP   = 8'h0B,
    OP_LSHI  = 8'h0C,
    OP_LSH   = 8'h0D
  } alu_op_e;

  // High nibble of the immediate-form opcodes
  localparam logic [3:0] OPI_ANDI = 4'h1;
  localparam logic [3:0] OPI_ORI  = 4'h2;
  localparam logic [3:0] OPI_XORI = 4'h3;
  localparam logic [3:0] OPI_ADDI = 4'h5;
  localparam logic [3:0] OPI_SUBI = 4'h9;
  localparam logic [3:0] OPI_CMPI = 4'hB;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm, input logic sgn);
    return {{(DATA_W-IMM_W){sgn & imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Issue, ALU-operand and writeback signals of the operand stage.
// slave = the stage itself, master = whoever drives it.
interface alu_operand_stage_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_opcode;
  logic [ADDR_W-1:0]   in_rdest;
  logic [ADDR_W-1:0]   in_rsrc;
  logic [IMM_W-1:0]    in_imm;
  logic                in_imm_sel;
  logic                in_imm_signed;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [OP_W-1:0]     alu_opcode;
  logic                alu_cin;
  logic [ADDR_W-1:0]   alu_rdest;
  logic                wb_en;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_flags_en;
  flags_t              wb_flags;
  flags_t              psr;

  modport slave (
    input  in_valid, in_opcode, in_rdest, in_rsrc, in_imm, in_imm_sel, in_imm_signed,
    input  out_ready, wb_en, wb_addr, wb_data, wb_flags_en, wb_flags,
    output in_ready, out_valid, alu_a, alu_b, alu_opcode, alu_cin, alu_rdest, psr
  );

  modport master (
    output in_valid, in_opcode, in_rdest, in_rsrc, in_imm, in_imm_sel, in_imm_signed,
    output out_ready, wb_en, wb_addr, wb_data, wb_flags_en, wb_flags,
    input  in_ready, out_valid, alu_a, alu_b, alu_opcode, alu_cin, alu_rdest, psr
  );

endinterface

// File: rtl/alu_regfile.sv
// 16x16 general register file: two combinational read ports, one clocked write port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] regs_q [REG_CNT];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_a_o = regs_q[rd_addr_a_i];
  assign rd_data_b_o = regs_q[rd_addr_b_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: register file, PSR and one valid/ready output slot.
// Define OPSTAGE_BYPASS_EN to forward same-cycle writeback into captured and stalled operands.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  alu_operand_stage_if.slave bus
);

  logic [DATA_W-1:0] rd_a, rd_b, a_sel, b_sel;
  logic              cin_sel, in_ready, capture;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              cin_q, cin_d;
  logic [ADDR_W-1:0] rdest_q, rdest_d;
  flags_t            psr_q, psr_d;

  alu_regfile u_regfile (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .rd_addr_a_i (bus.in_rdest),
    .rd_addr_b_i (bus.in_rsrc),
    .rd_data_a_o (rd_a),
    .rd_data_b_o (rd_b),
    .wr_en_i     (bus.wb_en),
    .wr_addr_i   (bus.wb_addr),
    .wr_data_i   (bus.wb_data)
  );

  assign in_ready = !valid_q || bus.out_ready;
  assign capture  = bus.in_valid && in_ready;

`ifdef OPSTAGE_BYPASS_EN
  logic [ADDR_W-1:0] tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic              b_reg_q, b_reg_d;

  always_comb begin
    a_sel   = (bus.wb_en && bus.wb_addr == bus.in_rdest) ? bus.wb_data : rd_a;
    b_sel   = ext_imm(bus.in_imm, bus.in_imm_signed);
    if (!bus.in_imm_sel)
      b_sel = (bus.wb_en && bus.wb_addr == bus.in_rsrc) ? bus.wb_data : rd_b;
    cin_sel = bus.wb_flags_en ? bus.wb_flags[FLAG_C] : psr_q[FLAG_C];
  end
`else
  assign a_sel   = rd_a;
  assign b_sel   = bus.in_imm_sel ? ext_imm(bus.in_imm, bus.in_imm_signed) : rd_b;
  assign cin_sel = psr_q[FLAG_C];
`endif

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cin_d   = cin_q;
    rdest_d = rdest_q;
    psr_d   = bus.wb_flags_en ? bus.wb_flags : psr_q;
`ifdef OPSTAGE_BYPASS_EN
    tag_a_d = tag_a_q;
    tag_b_d = tag_b_q;
    b_reg_d = b_reg_q;
`endif
    if (capture) begin
      valid_d = 1'b1;
      a_d     = a_sel;
      b_d     = b_sel;
      op_d    = bus.in_opcode;
      cin_d   = cin_sel;
      rdest_d = bus.in_rdest;
`ifdef OPSTAGE_BYPASS_EN
      tag_a_d = bus.in_rdest;
      tag_b_d = bus.in_rsrc;
      b_reg_d = !bus.in_imm_sel;
`endif
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
`ifdef OPSTAGE_BYPASS_EN
    end else if (valid_q) begin
      // Stalled: keep held operands coherent with writeback to their source registers
      if (bus.wb_en && bus.wb_addr == tag_a_q) a_d = bus.wb_data;
      if (bus.wb_en && b_reg_q && bus.wb_addr == tag_b_q) b_d = bus.wb_data;
      if (bus.wb_flags_en) cin_d = bus.wb_flags[FLAG_C];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      rdest_q <= '0;
      psr_q   <= '0;
`ifdef OPSTAGE_BYPASS_EN
      tag_a_q <= '0;
      tag_b_q <= '0;
      b_reg_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      rdest_q <= rdest_d;
      psr_q   <= psr_d;
`ifdef OPSTAGE_BYPASS_EN
      tag_a_q <= tag_a_d;
      tag_b_q <= tag_b_d;
      b_reg_q <= b_reg_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_opcode = op_q;
  assign bus.alu_cin    = cin_q;
  assign bus.alu_rdest  = rdest_q;
  assign bus.psr        = psr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a randomized run
// against a transaction-level model of the register file, PSR and output slot.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_operand_stage_if bus();
  alu_operand_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_regs [16];
  flags_t      m_psr;
  logic        m_valid;
  logic [15:0] m_a, m_b;
  logic [7:0]  m_op;
  logic        m_cin;
  logic [3:0]  m_rdest, m_src_a, m_src_b;
  logic        m_b_is_reg;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_psr = '0; m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_cin = 0; m_rdest = 0;
    m_src_a = 0; m_src_b = 0; m_b_is_reg = 0;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_opcode = 0; bus.in_rdest = 0; bus.in_rsrc = 0; bus.in_imm = 0;
    bus.in_imm_sel = 0; bus.in_imm_signed = 0; bus.out_ready = 1;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.wb_flags_en = 0; bus.wb_flags = 0;
  endtask

  task automatic issue(input logic [3:0] rd, input logic [3:0] rs, input logic [7:0] imm,
                       input logic isel, input logic isgn, input logic [7:0] op);
    bus.in_valid = 1; bus.in_rdest = rd; bus.in_rsrc = rs; bus.in_imm = imm;
    bus.in_imm_sel = isel; bus.in_imm_signed = isgn; bus.in_opcode = op;
  endtask

  // Advance one clock; model reacts to what was presented during the cycle.
  task automatic tick();
    logic rdy, cap, wen, fen;
    logic [3:0] waddr, rd, rs;
    logic [15:0] wdata, a, b;
    logic [7:0] op;
    logic isel, cin;
    flags_t wfl;
    rdy = !m_valid || bus.out_ready;
    cap = bus.in_valid && rdy;
    wen = bus.wb_en; waddr = bus.wb_addr; wdata = bus.wb_data;
    fen = bus.wb_flags_en; wfl = bus.wb_flags;
    rd = bus.in_rdest; rs = bus.in_rsrc; op = bus.in_opcode; isel = bus.in_imm_sel;
    a = m_regs[rd];
    if (isel) begin
      b = {8'h00, bus.in_imm};
      if (bus.in_imm_signed && bus.in_imm >= 8'h80) b = b + 16'hFF00;
    end else begin
      b = m_regs[rs];
    end
    cin = m_psr[FLAG_C];
`ifdef OPSTAGE_BYPASS_EN
    if (wen && waddr == rd) a = wdata;
    if (wen && !isel && waddr == rs) b = wdata;
    if (fen) cin = wfl[FLAG_C];
`endif
    @(posedge clk);
    if (cap) begin
      m_valid = 1; m_a = a; m_b = b; m_op = op; m_cin = cin; m_rdest = rd;
      m_src_a = rd; m_src_b = rs; m_b_is_reg = !isel;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
`ifdef OPSTAGE_BYPASS_EN
    else if (m_valid) begin
      if (wen && waddr == m_src_a) m_a = wdata;
      if (wen && m_b_is_reg && waddr == m_src_b) m_b = wdata;
      if (fen) m_cin = wfl[FLAG_C];
    end
`endif
    if (wen) m_regs[waddr] = wdata;
    if (fen) m_psr = wfl;
    #1;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
    idle();
    bus.wb_en = 1; bus.wb_addr = addr; bus.wb_data = data;
    tick();
    bus.wb_en = 0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    model_reset();
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0) begin failures++; $display("FAIL reset_operands got a=%h b=%h exp=0", bus.alu_a, bus.alu_b); end
    checks++; if (bus.alu_opcode !== 8'h0 || bus.alu_rdest !== 4'h0 || bus.alu_cin !== 1'b0) begin failures++; $display("FAIL reset_ctrl got op=%h rd=%h cin=%b exp=0", bus.alu_opcode, bus.alu_rdest, bus.alu_cin); end
    checks++; if (bus.psr !== 5'h0) begin failures++; $display("FAIL reset_psr got=%b exp=00000", bus.psr); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    write_reg(4'd3, 16'h1234);
    write_reg(4'd5, 16'h0010);
    idle();
    issue(4'd3, 4'd5, 8'h00, 0, 0, 8'h05);
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.alu_a !== 16'h1234 || bus.alu_b !== 16'h0010) begin failures++; $display("FAIL basic_operands got a=%h b=%h exp a=1234 b=0010", bus.alu_a, bus.alu_b); end
    checks++; if (bus.alu_opcode !== 8'h05 || bus.alu_rdest !== 4'd3) begin failures++; $display("FAIL basic_op got op=%h rd=%h exp op=05 rd=3", bus.alu_opcode, bus.alu_rdest); end
    idle();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_imm();
    idle();
    issue(4'd3, 4'd5, 8'hF0, 1, 1, 8'h05);
    tick();
    checks++; if (bus.alu_b !== 16'hFFF0) begin failures++; $display("FAIL imm_signed got=%h exp=fff0", bus.alu_b); end
    issue(4'd3, 4'd5, 8'hF0, 1, 0, 8'h05);
    tick();
    checks++; if (bus.alu_b !== 16'h00F0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL imm_unsigned got b=%h v=%b exp b=00f0 v=1", bus.alu_b, bus.out_valid); end
    issue(4'd5, 4'd3, 8'h7F, 1, 1, 8'h06);
    tick();
    checks++; if (bus.alu_b !== 16'h007F || bus.alu_a !== 16'h0010) begin failures++; $display("FAIL imm_pos got a=%h b=%h exp a=0010 b=007f", bus.alu_a, bus.alu_b); end
    idle();
    tick();
  endtask

  task automatic test_cin();
    logic exp_cin;
    idle();
    bus.wb_flags_en = 1; bus.wb_flags = 5'b01000;
    tick();
    checks++; if (bus.psr !== 5'b01000) begin failures++; $display("FAIL psr_load got=%b exp=01000", bus.psr); end
    idle();
    issue(4'd1, 4'd2, 8'h00, 0, 0, OP_ADDC);
    tick();
    checks++; if (bus.alu_cin !== 1'b1 || bus.alu_opcode !== OP_ADDC) begin failures++; $display("FAIL cin_set got cin=%b op=%h exp cin=1 op=07", bus.alu_cin, bus.alu_opcode); end
    bus.wb_flags_en = 1; bus.wb_flags = 5'b00000;
    tick();
`ifdef OPSTAGE_BYPASS_EN
    exp_cin = 1'b0;
`else
    exp_cin = 1'b1;
`endif
    checks++; if (bus.alu_cin !== exp_cin) begin failures++; $display("FAIL cin_same_cycle got=%b exp=%b", bus.alu_cin, exp_cin); end
    checks++; if (bus.psr !== 5'b00000) begin failures++; $display("FAIL psr_clear got=%b exp=00000", bus.psr); end
    idle();
    tick();
  endtask

  task automatic test_stall();
    logic [15:0] exp_b;
    write_reg(4'd3, 16'h1234);
    write_reg(4'd5, 16'h0010);
    idle();
    bus.out_ready = 0;
    issue(4'd3, 4'd5, 8'h00, 0, 0, 8'h11);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_opcode !== 8'h11) begin failures++; $display("FAIL stall_first got v=%b op=%h exp v=1 op=11", bus.out_valid, bus.alu_opcode); end
    issue(4'd5, 4'd5, 8'h00, 0, 0, 8'h22);
    bus.wb_en = 1; bus.wb_addr = 4'd5; bus.wb_data = 16'hBEEF;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
    tick();
`ifdef OPSTAGE_BYPASS_EN
    exp_b = 16'hBEEF;
`else
    exp_b = 16'h0010;
`endif
    checks++; if (bus.alu_opcode !== 8'h11 || bus.alu_a !== 16'h1234 || bus.alu_b !== exp_b) begin failures++; $display("FAIL stall_hold got op=%h a=%h b=%h exp op=11 a=1234 b=%h", bus.alu_opcode, bus.alu_a, bus.alu_b, exp_b); end
    bus.wb_en = 0;
    tick();
    checks++; if (bus.alu_opcode !== 8'h11 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_stable got op=%h v=%b exp op=11 v=1", bus.alu_opcode, bus.out_valid); end
    bus.out_ready = 1;
    tick();
    checks++; if (bus.alu_opcode !== 8'h22 || bus.alu_a !== 16'hBEEF || bus.alu_b !== 16'hBEEF) begin failures++; $display("FAIL stall_second got op=%h a=%h b=%h exp op=22 a=beef b=beef", bus.alu_opcode, bus.alu_a, bus.alu_b); end
    idle();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_no_dup got v=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 4'(i + 1), 8'(i * 16 + 3), 1, 0, 8'(8'h40 + i));
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.alu_opcode !== 8'(8'h40 + i) || bus.alu_b !== 16'(i * 16 + 3)) begin failures++; $display("FAIL b2b_%0d got v=%b op=%h b=%h exp v=1 op=%h b=%h", i, bus.out_valid, bus.alu_opcode, bus.alu_b, 8'(8'h40 + i), 16'(i * 16 + 3)); end
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.in_valid = 1'($urandom_range(0, 2) != 0);
      bus.in_opcode = 8'($urandom);
      bus.in_rdest = 4'($urandom_range(0, 3));
      bus.in_rsrc = 4'($urandom_range(0, 3));
      bus.in_imm = 8'($urandom);
      bus.in_imm_sel = 1'($urandom);
      bus.in_imm_signed = 1'($urandom);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.wb_en = 1'($urandom);
      bus.wb_addr = 4'($urandom_range(0, 3));
      bus.wb_data = 16'($urandom);
      bus.wb_flags_en = 1'($urandom_range(0, 3) == 0);
      bus.wb_flags = 5'($urandom);
      #1;
      checks++; if (bus.in_ready !== (!m_valid || bus.out_ready)) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", n, bus.in_ready, !m_valid || bus.out_ready); end
      tick();
      checks++; if (bus.out_valid !== m_valid || bus.psr !== m_psr) begin failures++; $display("FAIL rand_state cyc=%0d got v=%b psr=%b exp v=%b psr=%b", n, bus.out_valid, bus.psr, m_valid, m_psr); end
      if (m_valid) begin
        checks++; if (bus.alu_a !== m_a || bus.alu_b !== m_b || bus.alu_opcode !== m_op || bus.alu_cin !== m_cin || bus.alu_rdest !== m_rdest) begin
          failures++;
          $display("FAIL rand_operands cyc=%0d got a=%h b=%h op=%h cin=%b rd=%h exp a=%h b=%h op=%h cin=%b rd=%h", n, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_cin, bus.alu_rdest, m_a, m_b, m_op, m_cin, m_rdest);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    write_reg(4'd3, 16'h1234);
    idle();
    bus.out_ready = 0;
    issue(4'd3, 4'd0, 8'h00, 0, 0, 8'h33);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_a !== 16'h1234) begin failures++; $display("FAIL rstmid_pre got v=%b a=%h exp v=1 a=1234", bus.out_valid, bus.alu_a); end
    reset_n = 0;
    model_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.alu_a !== 16'h0 || bus.alu_opcode !== 8'h0) begin failures++; $display("FAIL rstmid_async got v=%b a=%h op=%h exp 0", bus.out_valid, bus.alu_a, bus.alu_opcode); end
    idle();
    #3;
    reset_n = 1;
    @(posedge clk); #1;
    issue(4'd3, 4'd3, 8'h00, 0, 0, 8'h05);
    tick();
    checks++; if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_r3 got v=%b a=%h b=%h exp v=1 a=0 b=0", bus.out_valid, bus.alu_a, bus.alu_b); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm();
    test_cin();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch pipeline stage sitting directly upstream of the 16-bit ALU.
- Holds the 16x16 general register file and the 5-bit processor status register (PSR, ZCFNL).
- Selects register or immediate B operand and registers A, B, Opcode and Cin into a single output stage for the ALU.
- Accepts ALU result and flag writeback from the downstream stage.

Parameters:
- DATA_W, 16, operand/result width
- REG_CNT, 16, number of general registers
- ADDR_W, 4, register address width (log2 REG_CNT)
- OP_W, 8, ALU opcode width
- FLAG_W, 5, PSR width, bit order ZCFNL (4=Z, 3=C, 2=F overflow, 1=N, 0=L)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction
- in_opcode  in  OP_W  ALU opcode, passed through
- in_rdest  in  ADDR_W  A-operand register (also the destination, forwarded)
- in_rsrc  in  ADDR_W  B-operand register
- in_imm  in  8  immediate
- in_imm_sel  in  1  1 = B comes from immediate
- in_imm_signed  in  1  1 = sign-extend imm, 0 = zero-extend
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream accepts operands
- alu_a, alu_b  out  DATA_W  ALU A/B
- alu_opcode  out  OP_W  ALU Opcode
- alu_cin  out  1  PSR carry sampled at issue
- alu_rdest  out  ADDR_W  destination tag for writeback
- wb_en  in  1  register write enable
- wb_addr  in  ADDR_W  write address
- wb_data  in  DATA_W  write data (ALU C)
- wb_flags_en  in  1  PSR write enable
- wb_flags  in  FLAG_W  ALU Flags
- psr  out  FLAG_W  current PSR

Behaviour:
- Reset (async, reset_n=0):
  - all registers and PSR clear to 0
  - out_valid=0; alu_a, alu_b, alu_opcode, alu_rdest clear to 0; alu_cin=0
  - reset mid-transfer discards the held instruction
- Handshake:
  - in_ready = !out_valid || out_ready (combinational)
  - capture when in_valid && in_ready; out_valid=1 the next cycle (latency 1)
  - out_valid falls only after out_valid && out_ready with no new capture
  - back-to-back accept every cycle when out_ready=1
  - outputs hold stable while out_valid && !out_ready
- Operand selection at capture:
  - A = R[in_rdest]
  - B = in_imm_sel ? ext(in_imm) : R[in_rsrc]
  - ext: {8{imm[7]}} when in_imm_signed=1, {8'h00} otherwise
  - alu_cin = PSR[3]
- Writeback:
  - wb_en writes R[wb_addr] at the clock edge
  - wb_flags_en loads PSR at the clock edge
  - writeback is independent of the handshake and accepted every cycle, including during a stall
  - simultaneous wb_en and capture proceed in the same cycle
- psr output = PSR register, not bypassed.

Optional Feature:
- Macro: OPSTAGE_BYPASS_EN.
- Defined:
  - Same-cycle bypass at capture: if wb_en and wb_addr matches the read address, the operand takes wb_data. Applies to A, and to B only when !in_imm_sel.
  - If wb_flags_en, alu_cin takes wb_flags[3].
  - While stalled (out_valid && !out_ready), a wb_en matching the held source refreshes alu_a and/or alu_b (B only if register-sourced; held tags are kept for this).
  - A wb_flags_en during a stall refreshes alu_cin.
- Undefined:
  - Reads see pre-write values; held operands are never refreshed.
  - No source tags are stored.

Decomposition:
- Package alu_pkg:
  - FLAG_Z/C/F/N/L bit-index constants
  - opcode constants: AND, OR, XOR, NOT, ADD, ADDU, ADDC, ADDCU, SUB, CMP, CMPU, LSHI, LSH, plus immediate-group high nibbles
  - width constants
  - typedef flags_t
- One sub-module, alu_regfile: 2 async read ports, 1 sync write port, async reset.
- Handshake, bypass and PSR logic stay in alu_operand_stage.

Test Plan:
- Reset, then write R3=16'h1234 and R5=16'h0010; issue rdest=3, rsrc=5, imm_sel=0, opcode=8'h05 -> next cycle out_valid=1, alu_a=16'h1234, alu_b=16'h0010, alu_opcode=8'h05.
- Issue imm=8'hF0 with imm_signed=1, then imm_signed=0 -> alu_b=16'hFFF0, then alu_b=16'h00F0.
- Write wb_flags=5'b01000, then issue ADDC -> alu_cin=1.
  - BYPASS_EN: same-cycle wb_flags=5'b00000 gives alu_cin=0.
- Hold out_ready=0 with an instruction valid, then present a second -> in_ready=0, outputs stable; raise out_ready -> second captured next cycle with no loss or duplication.
- BYPASS_EN: while stalled on rsrc=5, wb_en R5=16'hBEEF -> alu_b becomes 16'hBEEF next cycle.
  - Without BYPASS_EN: alu_b is unchanged.
- Assert reset_n=0 while out_valid=1 -> out_valid=0 and R3=0 immediately, without waiting for a clock.
